// File: rtl/hilo_unit.sv
// HI/LO architectural register pair with MEM/WB holding stages and reader forwarding.
// Build option: define HILO_FWD_EN to forward pending writes to hi/lo; otherwise hi/lo show committed state.
module hilo_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_we,
  input  logic [DATA_W-1:0] ex_hi,
  input  logic [DATA_W-1:0] ex_lo,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] arch_hi,
  output logic [DATA_W-1:0] arch_lo,
  output logic              commit,
  output logic              hilo_busy
);

  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_hi;
  logic [DATA_W-1:0] r_mem_lo;
  logic              r_wb_we;
  logic [DATA_W-1:0] r_wb_hi;
  logic [DATA_W-1:0] r_wb_lo;
  logic [DATA_W-1:0] r_arch_hi;
  logic [DATA_W-1:0] r_arch_lo;
  logic              r_commit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_we  <= 1'b0;
      r_mem_hi  <= '0;
      r_mem_lo  <= '0;
      r_wb_we   <= 1'b0;
      r_wb_hi   <= '0;
      r_wb_lo   <= '0;
      r_arch_hi <= '0;
      r_arch_lo <= '0;
      r_commit  <= 1'b0;
    end else begin
      // WB always retires whatever it holds, regardless of stall/flush.
      if (r_wb_we) begin
        r_arch_hi <= r_wb_hi;
        r_arch_lo <= r_wb_lo;
      end
      r_commit <= r_wb_we;

      // A held or discarded MEM entry leaves a bubble behind it in WB.
      if (stall || flush) begin
        r_wb_we <= 1'b0;
      end else begin
        r_wb_we <= r_mem_we;
        r_wb_hi <= r_mem_hi;
        r_wb_lo <= r_mem_lo;
      end

      if (flush) begin
        r_mem_we <= 1'b0;
      end else if (!stall) begin
        r_mem_we <= ex_we;
        r_mem_hi <= ex_hi;
        r_mem_lo <= ex_lo;
      end
    end
  end

  logic [DATA_W-1:0] w_fwd_hi;
  logic [DATA_W-1:0] w_fwd_lo;

  always_comb begin
    w_fwd_hi = r_arch_hi;
    w_fwd_lo = r_arch_lo;
`ifdef HILO_FWD_EN
    // Youngest pending stage wins; hi and lo always come from the same stage.
    if (r_mem_we) begin
      w_fwd_hi = r_mem_hi;
      w_fwd_lo = r_mem_lo;
    end else if (r_wb_we) begin
      w_fwd_hi = r_wb_hi;
      w_fwd_lo = r_wb_lo;
    end
`endif
  end

  assign hi        = w_fwd_hi;
  assign lo        = w_fwd_lo;
  assign arch_hi   = r_arch_hi;
  assign arch_lo   = r_arch_lo;
  assign commit    = r_commit;
  assign hilo_busy = r_mem_we | r_wb_we;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: a reference model pushes expected outputs per driven
// cycle into a queue, which is popped and compared against the DUT after the clock edge.
module tb_hilo_unit;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          flush;
  logic          ex_we;
  logic [DW-1:0] ex_hi;
  logic [DW-1:0] ex_lo;
  logic [DW-1:0] hi;
  logic [DW-1:0] lo;
  logic [DW-1:0] arch_hi;
  logic [DW-1:0] arch_lo;
  logic          commit;
  logic          hilo_busy;

  hilo_unit #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .ex_we     (ex_we),
    .ex_hi     (ex_hi),
    .ex_lo     (ex_lo),
    .hi        (hi),
    .lo        (lo),
    .arch_hi   (arch_hi),
    .arch_lo   (arch_lo),
    .commit    (commit),
    .hilo_busy (hilo_busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  typedef struct {
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic [DW-1:0] ahi;
    logic [DW-1:0] alo;
    logic          commit;
    logic          busy;
  } exp_t;

  exp_t q[$];

  // Reference pipeline state.
  logic          m_mem_we, m_wb_we, m_commit;
  logic [DW-1:0] m_mem_hi, m_mem_lo, m_wb_hi, m_wb_lo, m_arch_hi, m_arch_lo;

  task automatic m_reset();
    m_mem_we = 0; m_mem_hi = '0; m_mem_lo = '0;
    m_wb_we  = 0; m_wb_hi  = '0; m_wb_lo  = '0;
    m_arch_hi = '0; m_arch_lo = '0; m_commit = 0;
  endtask

  function automatic exp_t m_out();
    exp_t e;
    e.ahi = m_arch_hi;
    e.alo = m_arch_lo;
    e.hi  = m_arch_hi;
    e.lo  = m_arch_lo;
`ifdef HILO_FWD_EN
    if (m_mem_we) begin
      e.hi = m_mem_hi; e.lo = m_mem_lo;
    end else if (m_wb_we) begin
      e.hi = m_wb_hi; e.lo = m_wb_lo;
    end
`endif
    e.commit = m_commit;
    e.busy   = m_mem_we | m_wb_we;
    return e;
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = q.pop_front();
    check({tag, "_hi"},      hi,              e.hi);
    check({tag, "_lo"},      lo,              e.lo);
    check({tag, "_arch_hi"}, arch_hi,         e.ahi);
    check({tag, "_arch_lo"}, arch_lo,         e.alo);
    check({tag, "_commit"},  32'(commit),     32'(e.commit));
    check({tag, "_busy"},    32'(hilo_busy),  32'(e.busy));
  endtask

  // Called just after a rising edge: drive inputs, advance the model, push, then
  // compare after the next edge.
  task automatic cycle(input string tag, input logic s, input logic f, input logic we,
                       input logic [DW-1:0] h, input logic [DW-1:0] l);
    stall = s; flush = f; ex_we = we; ex_hi = h; ex_lo = l;
    if (m_wb_we) begin
      m_arch_hi = m_wb_hi; m_arch_lo = m_wb_lo;
    end
    m_commit = m_wb_we;
    if (s || f) m_wb_we = 0;
    else begin
      m_wb_we = m_mem_we; m_wb_hi = m_mem_hi; m_wb_lo = m_mem_lo;
    end
    if (f) m_mem_we = 0;
    else if (!s) begin
      m_mem_we = we; m_mem_hi = h; m_mem_lo = l;
    end
    q.push_back(m_out());
    @(posedge clk); #1;
    compare(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, '0, '0);
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0; ex_we = 0; ex_hi = '0; ex_lo = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    q.push_back(m_out());
    compare("reset");
    rst = 0;

    // Single write.
    cycle("single_w", 0, 0, 1, 32'h12345678, 32'h9ABCDEF0);
    check("single_busy_const", 32'(hilo_busy), 32'd1);
    idle("single_i", 2);
    check("single_arch_hi_const", arch_hi, 32'h12345678);
    check("single_arch_lo_const", arch_lo, 32'h9ABCDEF0);
    check("single_commit_const", 32'(commit), 32'd1);
    idle("single_tail", 1);

    // Back-to-back writes.
    cycle("b2b_a", 0, 0, 1, 32'd1, 32'd2);
    cycle("b2b_b", 0, 0, 1, 32'd3, 32'd4);
    idle("b2b_i", 4);
    check("b2b_arch_hi_const", arch_hi, 32'd3);

    // Write then 3-cycle stall.
    cycle("stall_w", 0, 0, 1, 32'd5, 32'd6);
    for (int i = 0; i < 3; i++) cycle("stall_s", 1, 0, 1, 32'hDEAD, 32'hBEEF);
    idle("stall_rel", 3);
    check("stall_arch_hi_const", arch_hi, 32'd5);
    check("stall_arch_lo_const", arch_lo, 32'd6);

    // Flush together with stall discards the MEM entry.
    cycle("fl_w", 0, 0, 1, 32'd7, 32'd8);
    cycle("fl_fs", 1, 1, 1, 32'd11, 32'd12);
    check("fl_busy_const", 32'(hilo_busy), 32'd0);
    idle("fl_i", 3);
    check("fl_arch_hi_const", arch_hi, 32'd5);

    // Write of (9,10) observed through hi/lo.
    cycle("nf_w", 0, 0, 1, 32'd9, 32'd10);
    idle("nf_i", 3);
    check("nf_hi_const", hi, 32'd9);
    check("nf_lo_const", lo, 32'd10);

    // Random traffic.
    for (int i = 0; i < 60; i++)
      cycle("rand", ($urandom_range(3) == 0), ($urandom_range(7) == 0),
            1'($urandom_range(1)), $urandom, $urandom);

    // Async reset mid-cycle with writes pending.
    cycle("rst_w1", 0, 0, 1, 32'hA5A5A5A5, 32'h5A5A5A5A);
    cycle("rst_w2", 0, 0, 1, 32'h11110000, 32'h00001111);
    #3 rst = 1;
    #1;
    m_reset();
    q.push_back(m_out());
    compare("async_rst");
    stall = 0; flush = 0; ex_we = 0;
    @(posedge clk); #1;
    rst = 0;
    idle("post_rst", 3);
    check("post_rst_arch_const", arch_hi, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
